// File: rtl/conv_out_streamer.sv
// Serialises the conv2 result matrix into a row-major valid/ready pixel stream with row/frame flags.
// Optional ReLU on the streamed values when CONV_STREAM_RELU_EN is defined.
module conv_out_streamer #(
    parameter int SIZE      = 320,
    parameter int SIZEKer   = 3,
    parameter int WIDTH_BIT = 16,
    localparam int OUT_DIM  = SIZE - SIZEKer + 1,
    localparam int CNT_W    = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1
) (
    input  logic                        clock,
    input  logic                        nreset,
    input  logic                        done_in,
    input  logic signed [WIDTH_BIT-1:0] matrix_in [OUT_DIM-1:0][OUT_DIM-1:0],
    output logic signed [WIDTH_BIT-1:0] m_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic                        m_last_col,
    output logic                        m_last,
    output logic                        busy,
    output logic                        frame_done
);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

    state_t                      state_q, state_d;
    logic                        done_prev_q;
    logic [CNT_W-1:0]            row_q, row_d;
    logic [CNT_W-1:0]            col_q, col_d;
    logic signed [WIDTH_BIT-1:0] data_q, data_d;
    logic                        last_col_q, last_col_d;
    logic                        last_q, last_d;

    logic             start;
    logic             beat;
    logic             col_end;
    logic             row_end;
    logic             final_beat;
    logic             load_en;
    logic [CNT_W-1:0] ld_row;
    logic [CNT_W-1:0] ld_col;

    function automatic logic signed [WIDTH_BIT-1:0] shape(input logic signed [WIDTH_BIT-1:0] v);
`ifdef CONV_STREAM_RELU_EN
        return (v < 0) ? '0 : v;
`else
        return v;
`endif
    endfunction

    assign start      = (state_q == S_IDLE) && done_in && !done_prev_q;
    assign beat       = (state_q == S_STREAM) && m_ready;
    assign col_end    = (col_q == CNT_W'(OUT_DIM - 1));
    assign row_end    = (row_q == CNT_W'(OUT_DIM - 1));
    assign final_beat = beat && row_end && col_end;
    assign load_en    = start || (beat && !final_beat);

    // Index of the element to present next: origin on start, otherwise row-major successor.
    always_comb begin
        ld_row = row_q;
        ld_col = col_q + CNT_W'(1);
        if (start) begin
            ld_row = '0;
            ld_col = '0;
        end else if (col_end) begin
            ld_row = row_q + CNT_W'(1);
            ld_col = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (nreset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_STREAM;
            S_STREAM: if (final_beat) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        m_valid    = (state_q == S_STREAM);
        busy       = (state_q != S_IDLE);
        frame_done = (state_q == S_DONE);
    end

    always_comb begin
        row_d      = row_q;
        col_d      = col_q;
        data_d     = data_q;
        last_col_d = last_col_q;
        last_d     = last_q;
        if (load_en) begin
            row_d      = ld_row;
            col_d      = ld_col;
            data_d     = shape(matrix_in[ld_row][ld_col]);
            last_col_d = (ld_col == CNT_W'(OUT_DIM - 1));
            last_d     = (ld_col == CNT_W'(OUT_DIM - 1)) && (ld_row == CNT_W'(OUT_DIM - 1));
        end
    end

    // done_prev resets high so a level held across reset release is not seen as a rise.
    always_ff @(posedge clock) begin
        if (nreset) begin
            done_prev_q <= 1'b1;
            row_q       <= '0;
            col_q       <= '0;
            data_q      <= '0;
            last_col_q  <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            done_prev_q <= done_in;
            row_q       <= row_d;
            col_q       <= col_d;
            data_q      <= data_d;
            last_col_q  <= last_col_d;
            last_q      <= last_d;
        end
    end

    assign m_data     = data_q;
    assign m_last_col = last_col_q;
    assign m_last     = last_q;

endmodule

// File: tb/tb_conv_out_streamer.sv
// Randomised and directed checks of conv_out_streamer against a row-major reference queue.
// Build with CONV_STREAM_RELU_EN defined to exercise the ReLU variant.
module tb_conv_out_streamer;

    localparam int SIZE    = 5;
    localparam int SIZEKer = 3;
    localparam int W       = 16;
    localparam int OD      = SIZE - SIZEKer + 1;
    localparam int NB      = OD * OD;

    logic                clock = 1'b0;
    logic                nreset;
    logic                done_in;
    logic                m_ready;
    logic signed [W-1:0] mat [OD-1:0][OD-1:0];
    logic signed [W-1:0] m_data;
    logic                m_valid;
    logic                m_last_col;
    logic                m_last;
    logic                busy;
    logic                frame_done;

    int chk_cnt = 0;
    int err_cnt = 0;

    always #5 clock = ~clock;

    conv_out_streamer #(
        .SIZE      (SIZE),
        .SIZEKer   (SIZEKer),
        .WIDTH_BIT (W)
    ) dut (
        .clock      (clock),
        .nreset     (nreset),
        .done_in    (done_in),
        .matrix_in  (mat),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last_col (m_last_col),
        .m_last     (m_last),
        .busy       (busy),
        .frame_done (frame_done)
    );

    task automatic check_eq(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int model_val(input int v);
`ifdef CONV_STREAM_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Start a frame (done_in must have been low at the previous edge) and follow it to completion.
    // mode 0: ready always high, 1: ready alternates 0,1, 2: random ready.
    task automatic run_frame(input int mode, input bit pulse, input string tag);
        int                  exp_q[$];
        int                  k;
        int                  cyc;
        int                  last_edge;
        logic signed [W-1:0] pd;
        logic                plc;
        logic                pl;
        logic                pstall;
        for (int i = 0; i < OD; i++)
            for (int j = 0; j < OD; j++)
                exp_q.push_back(model_val(int'(mat[i][j])));
        done_in = 1'b1;
        step();
        check_eq({tag, "_start_valid"}, m_valid, 1);
        k = 0;
        cyc = 0;
        last_edge = 0;
        pstall = 1'b0;
        pd = '0;
        plc = 1'b0;
        pl = 1'b0;
        while (k < NB && cyc < 200) begin
            cyc++;
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (cyc % 2 == 0);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            if (pulse && cyc == 3) done_in = 1'b0;
            if (pulse && cyc == 4) done_in = 1'b1;
            check_eq({tag, "_valid"}, m_valid, 1);
            check_eq({tag, "_fdone_low"}, frame_done, 0);
            if (pstall) begin
                check_eq({tag, "_hold_data"}, m_data, pd);
                check_eq({tag, "_hold_lastcol"}, m_last_col, plc);
                check_eq({tag, "_hold_last"}, m_last, pl);
            end
            if (m_ready) begin
                check_eq({tag, "_data"}, m_data, exp_q[k]);
                check_eq({tag, "_lastcol"}, m_last_col, (k % OD == OD - 1));
                check_eq({tag, "_last"}, m_last, (k == NB - 1));
                k++;
                last_edge = cyc;
            end
            pstall = !m_ready;
            pd = m_data;
            plc = m_last_col;
            pl = m_last;
            step();
        end
        check_eq({tag, "_beats"}, k, NB);
        if (mode == 0) check_eq({tag, "_final_edge"}, last_edge, NB);
        if (mode == 1) check_eq({tag, "_final_edge"}, last_edge, 2 * NB);
        check_eq({tag, "_fdone"}, frame_done, 1);
        check_eq({tag, "_busy_done"}, busy, 1);
        check_eq({tag, "_valid_done"}, m_valid, 0);
        step();
        check_eq({tag, "_fdone_after"}, frame_done, 0);
        check_eq({tag, "_busy_after"}, busy, 0);
        repeat (5) begin
            step();
            check_eq({tag, "_no_extra"}, m_valid, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        nreset  = 1'b1;
        done_in = 1'b1;
        m_ready = 1'b0;
        for (int i = 0; i < OD; i++)
            for (int j = 0; j < OD; j++)
                mat[i][j] = W'(3 * i + j - 4);

        repeat (3) step();
        check_eq("rst_data", m_data, 0);
        check_eq("rst_valid", m_valid, 0);
        check_eq("rst_lastcol", m_last_col, 0);
        check_eq("rst_last", m_last, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_fdone", frame_done, 0);
        nreset = 1'b0;
        repeat (20) begin
            step();
            check_eq("rst_release_idle", m_valid, 0);
        end

        done_in = 1'b0;
        step();
        m_ready = 1'b1;
        run_frame(0, 1'b0, "full");

        repeat (20) begin
            step();
            check_eq("held_high_idle", m_valid, 0);
        end

        done_in = 1'b0;
        step();
        run_frame(0, 1'b0, "retrig");

        done_in = 1'b0;
        step();
        run_frame(1, 1'b0, "bp");

        done_in = 1'b0;
        step();
        run_frame(0, 1'b1, "midpulse");

        // Reset after four beats: the fifth element (0) is on the bus when reset hits.
        done_in = 1'b0;
        step();
        done_in = 1'b1;
        m_ready = 1'b1;
        step();
        repeat (4) step();
        check_eq("midrst_valid_pre", m_valid, 1);
        check_eq("midrst_data_pre", m_data, model_val(int'(mat[1][1])));
        nreset = 1'b1;
        step();
        check_eq("midrst_valid", m_valid, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_fdone", frame_done, 0);
        nreset = 1'b0;
        repeat (5) begin
            step();
            check_eq("midrst_no_fdone", frame_done, 0);
            check_eq("midrst_idle", m_valid, 0);
        end

        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < OD; i++)
                for (int j = 0; j < OD; j++)
                    mat[i][j] = W'(int'($urandom_range(0, 200)) - 100);
            done_in = 1'b0;
            step();
            run_frame(2, 1'b0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/conv_out_streamer.md
# conv_out_streamer

Reads the result matrix that the 2-D convolution core (`conv2`) exposes once it asserts `done`, and streams it out one element per beat in row-major order over a valid/ready interface. It sits directly downstream of `conv2`, turning the parallel `convIxKernelOut` array into a serial pixel stream for the next stage or a write-back port. Frame boundaries are marked with row and frame last flags and a completion pulse.

## Interface
Parameters:
- `SIZE`, 320, input image side length; must match the `conv2` instance.
- `SIZEKer`, 3, kernel side length; must match the `conv2` instance.
- `WIDTH_BIT`, 16, signed element width.
- Derived (localparam): `OUT_DIM = SIZE-SIZEKer+1`; `CNT_W = $clog2(OUT_DIM)`, minimum 1.

Ports:
- `clock`  in  1  sole clock; all logic on its rising edge.
- `nreset`  in  1  reset, synchronous, active-high. The name is kept for codebase consistency; a 1 resets.
- `done_in`  in  1  `conv2` `done`; level, held high while the matrix is valid.
- `matrix_in`  in  signed `[WIDTH_BIT-1:0]` `[OUT_DIM-1:0][OUT_DIM-1:0]`  `conv2` `convIxKernelOut`; must be stable from the start edge until `frame_done`.
- `m_data`  out  signed `WIDTH_BIT`  current element.
- `m_valid`  out  1  `m_data` is valid.
- `m_ready`  in  1  sink accepts; a beat completes at an edge where `m_valid && m_ready`.
- `m_last_col`  out  1  current element is in the last column (`col == OUT_DIM-1`).
- `m_last`  out  1  current element is the final element of the frame.
- `busy`  out  1  FSM is not in IDLE.
- `frame_done`  out  1  one-cycle pulse after the final beat.

## Operation
- FSM states:
  - IDLE: on a start event, go to STREAM.
  - STREAM: after the final beat, go to DONE.
  - DONE: go to IDLE unconditionally.
- Start event: `done_in==1` while `done_prev==0`, sampled in IDLE. `done_prev` is a register sampling `done_in` every cycle.
- Row/column counters `row` and `col`, each `CNT_W` bits, are zeroed on entry to STREAM.
- On each beat:
  - `col` increments.
  - At `col==OUT_DIM-1`, `col` wraps to 0 and `row` increments.
  - At `row==OUT_DIM-1 && col==OUT_DIM-1`, the beat is final and the FSM moves to DONE.
- `m_data` is registered from `matrix_in[row][col]` and loaded for the next index on entry to STREAM and on each non-final beat.
- While `m_valid && !m_ready`, `m_data`, `m_last_col` and `m_last` hold unchanged.
- `m_valid=1` exactly in STREAM. `busy=1` in STREAM and DONE. `frame_done=1` exactly in DONE.
- Start events are not detected in STREAM or DONE; a `done_in` rise during a frame is ignored.
- Another frame requires `done_in` to fall and rise again after the FSM returns to IDLE.
- Values pass through as-is: no arithmetic, no width change. The exception is the Configuration option below.

## Timing
- Reset (`nreset=1` at an edge):
  - FSM goes to IDLE.
  - `m_data`, `m_valid`, `m_last_col`, `m_last`, `busy`, `frame_done`, `row` and `col` all go to 0.
  - `done_prev` goes to 1.
  - Reset has priority over every other event, mid-frame included; the frame is abandoned with no `frame_done`.
- Because `done_prev` resets to 1, a `done_in` held high across reset release does not start a frame.
- Start at edge N → `m_valid=1` with element [0][0] from cycle N+1.
- With `m_ready` tied high: one beat per cycle, beats at edges N+1 … N+OUT_DIM².
- `frame_done` is high for the single cycle after the final beat edge. `busy` falls one cycle later.
- Minimum start-to-start spacing is OUT_DIM²+3 cycles.

## Configuration
- `CONV_STREAM_RELU_EN`:
  - Defined: the value loaded into `m_data` is `0` when the source element is negative, otherwise the element unchanged (ReLU).
  - Undefined: elements pass through unchanged as two's complement.
- Flags, latency and handshake are identical in both builds.

## Test plan
Benches use `SIZE=5`, `SIZEKer=3` (OUT_DIM=3), with `matrix_in[i][j] = 3*i+j-4`.
- Reset: hold `nreset=1` for 3 cycles with `done_in=1` → all outputs 0. Release with `done_in` still 1 → no frame starts; `m_valid` stays 0 for 20 cycles.
- Full frame, `m_ready=1`, `done_in` rises at edge N:
  - 9 beats at edges N+1…N+9 with `m_data` = −4,−3,…,4.
  - `m_last_col` on beats 3, 6 and 9; `m_last` on beat 9 only.
  - `frame_done=1` only in cycle N+10; `busy=0` from N+11.
- Backpressure: `m_ready` alternates 0,1 each cycle → same 9 values in order; `m_data` stable through every stall; final beat at edge N+18.
- Retrigger:
  - `done_in` held high after the frame → no second frame.
  - Drop `done_in` for 1 cycle and raise it → second identical frame.
  - Pulse `done_in` low→high during STREAM → ignored; exactly 9 beats.
- Reset mid-frame after beat 4 (`m_data=0` presented) → next cycle `m_valid=0`, `busy=0`, no `frame_done` pulse.
- `CONV_STREAM_RELU_EN` defined, full frame → `m_data` = 0,0,0,0,0,1,2,3,4 with unchanged timing.
